// File: rtl/pkt_bram_pkg.sv
// Shared definitions for the packet BRAM: geometry, header word layout,
// writer FSM encoding and header helpers used by writer and reader.
package pkt_bram_pkg;

    localparam int BRAM_ADDR_W   = 16;
    localparam int BRAM_DATA_W   = 64;
    localparam int PKT_SLOT_LOG2 = 5;
    localparam int HDR_CNT_W     = 6;

    // Writer FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;
    localparam logic [1:0] ST_HEADER  = 2'd3;

    // Header word, MSB first: valid, err, word count, flow, protocol, len, pkt_num, zero pad
    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic [HDR_CNT_W-1:0] cnt;
        logic [7:0]           flow_id;
        logic [7:0]           protocol;
        logic [7:0]           len;
        logic [2:0]           num;
        logic [28:0]          rsvd;
    } pkt_hdr_t;

    function automatic logic [BRAM_DATA_W-1:0] hdr_pack(input pkt_hdr_t h);
        return h;
    endfunction

    function automatic pkt_hdr_t hdr_unpack(input logic [BRAM_DATA_W-1:0] w);
        return w;
    endfunction

    // Payload words a packet of len bytes should occupy; a zero-length packet still carries one word
    function automatic logic [HDR_CNT_W-1:0] exp_words(input logic [7:0] len);
        if (len == 8'd0)
            return HDR_CNT_W'(1);
        return HDR_CNT_W'(({1'b0, len} + 9'd7) >> 3);
    endfunction

endpackage

// File: rtl/pkt_bram_writer_if.sv
// Beat-serial packet stream: valid/ready handshake, sop/eop framing and
// per-packet metadata qualified by sop.
interface pkt_bram_writer_if;
    import pkt_bram_pkg::*;

    logic                   valid;
    logic                   ready;
    logic                   sop;
    logic                   eop;
    logic [BRAM_DATA_W-1:0] data;
    logic [7:0]             len;
    logic [2:0]             num;
    logic [7:0]             protocol;
    logic [7:0]             flow_id;

    modport master (output valid, sop, eop, data, len, num, protocol, flow_id, input ready);
    modport slave  (input valid, sop, eop, data, len, num, protocol, flow_id, output ready);

endinterface

// File: rtl/pkt_bram_writer.sv
// Packet-to-BRAM store engine: writes each packet into a fixed slot of the
// packet BRAM, then commits it with a header word at offset 0 of the slot.
module pkt_bram_writer
    import pkt_bram_pkg::*;
#(
    parameter int ADDR_W    = BRAM_ADDR_W,
    parameter int DATA_W    = BRAM_DATA_W,
    parameter int SLOT_LOG2 = PKT_SLOT_LOG2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    pkt_bram_writer_if.slave              pkt,
    input  logic                          i_slot_release,
    output logic                          o_bram_en,
    output logic                          o_bram_we,
    output logic [ADDR_W-1:0]             o_bram_addr,
    output logic [DATA_W-1:0]             o_bram_din,
    output logic                          o_commit_valid,
    output logic [ADDR_W-SLOT_LOG2-1:0]   o_commit_slot,
    output logic [ADDR_W-SLOT_LOG2:0]     o_slots_used,
    output logic [1:0]                    o_err_sticky
);

    localparam int SLOT_W = ADDR_W - SLOT_LOG2;
    localparam int USED_W = SLOT_W + 1;
    localparam logic [USED_W-1:0]    NUM_SLOTS = USED_W'(1) << SLOT_W;
    localparam logic [HDR_CNT_W-1:0] MAX_WORDS = HDR_CNT_W'((1 << SLOT_LOG2) - 1);

    logic [1:0]           state_q,        state_d;
    logic [SLOT_W-1:0]    wr_slot_q,      wr_slot_d;
    logic [HDR_CNT_W-1:0] cnt_q,          cnt_d;
    logic                 err_q,          err_d;
    logic [7:0]           len_q,          len_d;
    logic [2:0]           num_q,          num_d;
    logic [7:0]           proto_q,        proto_d;
    logic [7:0]           flow_q,         flow_d;
    logic [USED_W-1:0]    used_q,         used_d;
    logic [1:0]           err_sticky_q,   err_sticky_d;
    logic                 bram_en_q,      bram_en_d;
    logic                 bram_we_q,      bram_we_d;
    logic [ADDR_W-1:0]    bram_addr_q,    bram_addr_d;
    logic [DATA_W-1:0]    bram_din_q,     bram_din_d;
    logic                 commit_valid_q, commit_valid_d;
    logic [SLOT_W-1:0]    commit_slot_q,  commit_slot_d;

    logic                 ready;
    logic                 accept;
    logic                 reserve;
    logic                 rel_ok;
    logic [HDR_CNT_W-1:0] cnt_inc;
    logic                 hdr_err;
    pkt_hdr_t             hdr;

    // Ready: held low in reset and during the header bubble; a full ring blocks only new packets
    always_comb begin
        ready = 1'b0;
        if (i_rst) begin
            case (state_q)
                ST_IDLE:             ready = (used_q != NUM_SLOTS);
                ST_PAYLOAD, ST_DROP: ready = 1'b1;
                default:             ready = 1'b0;
            endcase
        end
    end

    assign pkt.ready = ready;
    assign accept    = pkt.valid & ready;
    assign cnt_inc   = cnt_q + HDR_CNT_W'(1);

    // Packet FSM, payload/header write register and commit pulse
    always_comb begin
        state_d        = state_q;
        wr_slot_d      = wr_slot_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        len_d          = len_q;
        num_d          = num_q;
        proto_d        = proto_q;
        flow_d         = flow_q;
        err_sticky_d   = err_sticky_q;
        bram_en_d      = 1'b0;
        bram_we_d      = 1'b0;
        bram_addr_d    = bram_addr_q;
        bram_din_d     = bram_din_q;
        commit_valid_d = 1'b0;
        commit_slot_d  = commit_slot_q;
        reserve        = 1'b0;
        hdr_err        = err_q | (exp_words(len_q) != cnt_q);
        hdr            = '{valid: 1'b1, err: hdr_err, cnt: cnt_q, flow_id: flow_q,
                           protocol: proto_q, len: len_q, num: num_q, rsvd: '0};

        case (state_q)
            ST_IDLE: begin
                if (accept && pkt.sop) begin
                    // sop beat reserves the slot and is payload word 1
                    reserve     = 1'b1;
                    len_d       = pkt.len;
                    num_d       = pkt.num;
                    proto_d     = pkt.protocol;
                    flow_d      = pkt.flow_id;
                    err_d       = 1'b0;
                    cnt_d       = HDR_CNT_W'(1);
                    bram_en_d   = 1'b1;
                    bram_we_d   = 1'b1;
                    bram_addr_d = {wr_slot_q, SLOT_LOG2'(1)};
                    bram_din_d  = pkt.data;
                    state_d     = pkt.eop ? ST_HEADER : ST_PAYLOAD;
                end else if (accept) begin
                    // stray beat outside a packet: swallow it and flag
                    err_sticky_d[0] = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    cnt_d       = cnt_inc;
                    bram_en_d   = 1'b1;
                    bram_we_d   = 1'b1;
                    bram_addr_d = {wr_slot_q, cnt_inc[SLOT_LOG2-1:0]};
                    bram_din_d  = pkt.data;
                    if (pkt.sop)
                        err_d = 1'b1;
                    if (pkt.eop)
                        state_d = ST_HEADER;
                    else if (cnt_inc == MAX_WORDS)
                        state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                // slot is full: remaining beats are consumed but not stored
                err_d = 1'b1;
                if (accept && pkt.eop)
                    state_d = ST_HEADER;
            end
            default: begin
                bram_en_d       = 1'b1;
                bram_we_d       = 1'b1;
                bram_addr_d     = {wr_slot_q, SLOT_LOG2'(0)};
                bram_din_d      = hdr_pack(hdr);
                err_sticky_d[0] = err_sticky_q[0] | hdr_err;
                commit_valid_d  = 1'b1;
                commit_slot_d   = wr_slot_q;
                wr_slot_d       = wr_slot_q + SLOT_W'(1);
                state_d         = ST_IDLE;
            end
        endcase

        // Slot occupancy: release at zero is ignored and flagged
        rel_ok = i_slot_release && (used_q != '0);
        if (i_slot_release && (used_q == '0))
            err_sticky_d[1] = 1'b1;
        used_d = used_q;
        if (reserve && !rel_ok)
            used_d = used_q + USED_W'(1);
        else if (!reserve && rel_ok)
            used_d = used_q - USED_W'(1);
    end

    // State registers; reset abandons any open slot and restarts the ring at slot 0
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= ST_IDLE;
            wr_slot_q      <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            len_q          <= '0;
            num_q          <= '0;
            proto_q        <= '0;
            flow_q         <= '0;
            used_q         <= '0;
            err_sticky_q   <= '0;
            bram_en_q      <= 1'b0;
            bram_we_q      <= 1'b0;
            bram_addr_q    <= '0;
            bram_din_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_slot_q  <= '0;
        end else begin
            state_q        <= state_d;
            wr_slot_q      <= wr_slot_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            len_q          <= len_d;
            num_q          <= num_d;
            proto_q        <= proto_d;
            flow_q         <= flow_d;
            used_q         <= used_d;
            err_sticky_q   <= err_sticky_d;
            bram_en_q      <= bram_en_d;
            bram_we_q      <= bram_we_d;
            bram_addr_q    <= bram_addr_d;
            bram_din_q     <= bram_din_d;
            commit_valid_q <= commit_valid_d;
            commit_slot_q  <= commit_slot_d;
        end
    end

    assign o_bram_en      = bram_en_q;
    assign o_bram_we      = bram_we_q;
    assign o_bram_addr    = bram_addr_q;
    assign o_bram_din     = bram_din_q;
    assign o_commit_valid = commit_valid_q;
    assign o_commit_slot  = commit_slot_q;
    assign o_slots_used   = used_q;
    assign o_err_sticky   = err_sticky_q;

endmodule
